// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between execute and writeback
//
// Purpose: captures one instruction from execute, either forwards it straight
// to writeback, traps it as misaligned, or performs a big-endian load/store on
// a 64-bit data-memory port before completing it as a one-cycle mem_wb pulse.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   exe_mem         execute presents a valid instruction
//   result          effective address (load/store) or writeback value
//   mem_op          00/11 pass-through, 01 load, 10 store
//   mem_size        log2 of access size in bytes
//   mem_signed      sign-extend load data
//   store_data      right-justified store value
//   rd              destination register
//   mem_blocked     execute must hold its outputs
//   dmem_*          data-memory request/response port
//   mem_wb          one-cycle completion pulse
//   wb_we/rd/data   writeback controls, qualified by mem_wb
//   align_trap      misaligned-access pulse, coincident with mem_wb
module mem_stage #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exe_mem,
  input  logic [ADDR_W-1:0] result,
  input  logic [1:0]        mem_op,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] store_data,
  input  logic [4:0]        rd,
  output logic              mem_blocked,
  output logic              dmem_req,
  input  logic              dmem_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_resp,
  input  logic [ADDR_W-1:0] dmem_rdata,
  output logic              mem_wb,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [ADDR_W-1:0] wb_data,
  output logic              align_trap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [7:0]        dmem_wstrb_q, dmem_wstrb_d;
  logic [2:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [4:0]        rd_q, rd_d;
  logic              mem_wb_q, mem_wb_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [ADDR_W-1:0] wb_data_q, wb_data_d;
  logic              align_trap_q, align_trap_d;

  // Distance in bytes from the least-significant lane to the last byte of the
  // access: 8 - off - 2^size. Evaluated mod 8, so a doubleword (2^3 = 0 mod 8)
  // at offset 0 correctly yields 0.
  function automatic logic [2:0] byte_shift(input logic [2:0] off, input logic [1:0] size);
    logic [2:0] n;
    n = 3'(4'd1 << size);
    return 3'd0 - off - n;
  endfunction

  function automatic logic [7:0] lane_strb(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << byte_shift(off, size);
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] lane_wdata(input logic [63:0] data, input logic [2:0] off,
                                             input logic [1:0] size);
    return (data & size_mask(size)) << {byte_shift(off, size), 3'b000};
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] rdata, input logic [2:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [63:0] sh;
    sh = rdata >> {byte_shift(off, size), 3'b000};
    case (size)
      2'd0:    return {{56{sgn & sh[7]}},  sh[7:0]};
      2'd1:    return {{48{sgn & sh[15]}}, sh[15:0]};
      2'd2:    return {{32{sgn & sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  logic is_mem_op;
  assign is_mem_op = (mem_op == 2'b01) || (mem_op == 2'b10);

  always_comb begin
    state_d      = state_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_we_d    = dmem_we_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    rd_d         = rd_q;
    mem_wb_d     = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    align_trap_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (exe_mem) begin
          if (!is_mem_op) begin
            mem_wb_d  = 1'b1;
            wb_we_d   = 1'b1;
            wb_rd_d   = rd;
            wb_data_d = result;
          end else if (misaligned(result[2:0], mem_size)) begin
            mem_wb_d     = 1'b1;
            align_trap_d = 1'b1;
            wb_rd_d      = rd;
          end else begin
            // Request fields are registered here so they stay stable for the
            // whole REQ phase regardless of how long memory stalls.
            state_d      = REQ;
            dmem_addr_d  = {result[ADDR_W-1:3], 3'b000};
            dmem_we_d    = (mem_op == 2'b10);
            dmem_wstrb_d = lane_strb(result[2:0], mem_size);
            dmem_wdata_d = (mem_op == 2'b10) ? lane_wdata(store_data, result[2:0], mem_size)
                                             : '0;
            off_d        = result[2:0];
            size_d       = mem_size;
            signed_d     = mem_signed;
            rd_d         = rd;
          end
        end
      end
      REQ: begin
        if (dmem_ready) begin
          if (dmem_we_q) begin
            state_d  = IDLE;
            mem_wb_d = 1'b1;
            wb_rd_d  = rd_q;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_resp) begin
          state_d   = IDLE;
          mem_wb_d  = 1'b1;
          wb_we_d   = 1'b1;
          wb_rd_d   = rd_q;
          wb_data_d = load_extract(dmem_rdata, off_q, size_q, signed_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dmem_addr_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
      off_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      rd_q         <= '0;
      mem_wb_q     <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      align_trap_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_we_q    <= dmem_we_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      off_q        <= off_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      rd_q         <= rd_d;
      mem_wb_q     <= mem_wb_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      align_trap_q <= align_trap_d;
    end
  end

  // Decoded straight from the state register so an asynchronous reset drops
  // both immediately.
  assign mem_blocked = (state_q != IDLE);
  assign dmem_req    = (state_q == REQ);

  assign dmem_addr  = dmem_addr_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wstrb = dmem_wstrb_q;
  assign mem_wb     = mem_wb_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign align_trap = align_trap_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_mem;
  logic [63:0] result;
  logic [1:0]  mem_op;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [63:0] store_data;
  logic [4:0]  rd;
  logic        mem_blocked;
  logic        dmem_req;
  logic        dmem_ready;
  logic [63:0] dmem_addr;
  logic        dmem_we;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_resp;
  logic [63:0] dmem_rdata;
  logic        mem_wb;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        align_trap;

  mem_stage #(.ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .exe_mem(exe_mem), .result(result), .mem_op(mem_op),
    .mem_size(mem_size), .mem_signed(mem_signed), .store_data(store_data), .rd(rd),
    .mem_blocked(mem_blocked), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .mem_wb(mem_wb), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .align_trap(align_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        trap;
    logic [4:0]  rd;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (mem_wb === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_mem_wb: got mem_wb=1, expected no completion (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("wb_cycle", 64'(cyc), 64'(e.cyc));
        check("wb_we", {63'd0, wb_we}, {63'd0, e.we});
        check("align_trap", {63'd0, align_trap}, {63'd0, e.trap});
        if (e.we) begin
          check("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
          check("wb_data", wb_data, e.data);
        end
      end
    end else if (reset === 1'b0) begin
      check("trap_without_wb", {63'd0, align_trap}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input logic we, input logic trap, input logic [4:0] r,
                           input logic [63:0] d, input int at);
    exp_t x;
    x.we = we; x.trap = trap; x.rd = r; x.data = d; x.cyc = at;
    sb.push_back(x);
  endtask

  task automatic present(input logic [1:0] op, input logic [63:0] res, input logic [1:0] sz,
                         input logic sgn, input logic [63:0] sd, input logic [4:0] r);
    exe_mem = 1'b1; mem_op = op; result = res; mem_size = sz;
    mem_signed = sgn; store_data = sd; rd = r;
  endtask

  // Load with immediate acceptance; response after resp_delay idle WAIT cycles.
  task automatic do_load(input logic [63:0] res, input logic [1:0] sz, input logic sgn,
                         input logic [4:0] r, input logic [63:0] rdata,
                         input logic [63:0] exp_data, input int resp_delay);
    present(2'b01, res, sz, sgn, 64'd0, r);
    expect_wb(1'b1, 1'b0, r, exp_data, cyc + 3 + resp_delay);
    tick();
    exe_mem = 1'b0;
    dmem_ready = 1'b1;
    check("ld_req", {63'd0, dmem_req}, 64'd1);
    check("ld_addr", dmem_addr, res & ~64'd7);
    check("ld_we", {63'd0, dmem_we}, 64'd0);
    tick();
    dmem_ready = 1'b0;
    for (int i = 0; i < resp_delay; i++) begin
      check("ld_wait_blocked", {63'd0, mem_blocked}, 64'd1);
      tick();
    end
    dmem_resp = 1'b1;
    dmem_rdata = rdata;
    check("ld_wait_noreq", {63'd0, dmem_req}, 64'd0);
    tick();
    dmem_resp = 1'b0;
    dmem_rdata = 64'd0;
  endtask

  // Store with `stall` cycles of dmem_ready low before acceptance.
  task automatic do_store(input logic [63:0] res, input logic [1:0] sz, input logic [63:0] sd,
                          input logic [4:0] r, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wdata, input int stall);
    int blocked;
    blocked = 0;
    present(2'b10, res, sz, 1'b0, sd, r);
    expect_wb(1'b0, 1'b0, r, 64'd0, cyc + 2 + stall);
    tick();
    exe_mem = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      dmem_ready = (i == stall);
      if (mem_blocked) blocked++;
      check("st_req", {63'd0, dmem_req}, 64'd1);
      check("st_addr", dmem_addr, res & ~64'd7);
      check("st_we", {63'd0, dmem_we}, 64'd1);
      check("st_wstrb", {56'd0, dmem_wstrb}, {56'd0, exp_strb});
      check("st_wdata", dmem_wdata, exp_wdata);
      tick();
    end
    dmem_ready = 1'b0;
    check("st_blocked_cycles", 64'(blocked), 64'(stall + 1));
    check("st_unblocked", {63'd0, mem_blocked}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; exe_mem = 1'b0; result = '0; mem_op = '0; mem_size = '0;
    mem_signed = 1'b0; store_data = '0; rd = '0; dmem_ready = 1'b0;
    dmem_resp = 1'b0; dmem_rdata = '0;
    tick();
    tick();
    check("rst_blocked", {63'd0, mem_blocked}, 64'd0);
    check("rst_req", {63'd0, dmem_req}, 64'd0);
    check("rst_mem_wb", {63'd0, mem_wb}, 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_wstrb", {56'd0, dmem_wstrb}, 64'd0);
    reset = 1'b0;
    tick();

    // Pass-through, then two back-to-back.
    present(2'b00, 64'h1234, 2'd0, 1'b0, 64'd0, 5'd5);
    expect_wb(1'b1, 1'b0, 5'd5, 64'h1234, cyc + 1);
    tick();
    check("pt_not_blocked", {63'd0, mem_blocked}, 64'd0);
    present(2'b11, 64'hDEAD_BEEF_0000_0001, 2'd3, 1'b0, 64'd0, 5'd6);
    expect_wb(1'b1, 1'b0, 5'd6, 64'hDEAD_BEEF_0000_0001, cyc + 1);
    tick();
    present(2'b00, 64'h77, 2'd1, 1'b0, 64'd0, 5'd31);
    expect_wb(1'b1, 1'b0, 5'd31, 64'h77, cyc + 1);
    tick();
    exe_mem = 1'b0;
    tick();

    // Loads: signed byte, unsigned byte at last lane, zero-extended half,
    // signed word, doubleword pass-through.
    do_load(64'h1003, 2'd0, 1'b1, 5'd7, 64'h0000_00F0_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 0);
    do_load(64'h6007, 2'd0, 1'b0, 5'd8, 64'h1111_1111_1111_1180, 64'h80, 1);
    do_load(64'h4004, 2'd1, 1'b0, 5'd9, 64'h0000_0000_ABCD_0000, 64'hABCD, 0);
    do_load(64'h5000, 2'd2, 1'b1, 5'd10, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 2);
    do_load(64'h7008, 2'd3, 1'b1, 5'd12, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 0);

    // Stores: half with 3-cycle backpressure, word in upper lanes, byte.
    do_store(64'h2006, 2'd1, 64'hBEEF, 5'd3, 8'h03, 64'hBEEF, 3);
    do_store(64'h5000, 2'd2, 64'h1122_3344_5566_7788, 5'd4, 8'hF0, 64'h5566_7788_0000_0000, 0);
    do_store(64'h5001, 2'd0, 64'hAB, 5'd4, 8'h40, 64'h00AB_0000_0000_0000, 1);

    // Misaligned word load and misaligned doubleword store.
    present(2'b01, 64'h3002, 2'd2, 1'b0, 64'd0, 5'd13);
    expect_wb(1'b0, 1'b1, 5'd13, 64'd0, cyc + 1);
    tick();
    exe_mem = 1'b0;
    check("mis_no_req", {63'd0, dmem_req}, 64'd0);
    check("mis_not_blocked", {63'd0, mem_blocked}, 64'd0);
    present(2'b10, 64'h3004, 2'd3, 1'b0, 64'h55, 5'd14);
    expect_wb(1'b0, 1'b1, 5'd14, 64'd0, cyc + 1);
    tick();
    exe_mem = 1'b0;
    check("mis_st_no_req", {63'd0, dmem_req}, 64'd0);
    tick();

    // Held pass-through behind a load.
    present(2'b01, 64'h4004, 2'd1, 1'b1, 64'd0, 5'd9);
    expect_wb(1'b1, 1'b0, 5'd9, 64'hFFFF_FFFF_FFFF_ABCD, cyc + 3);
    expect_wb(1'b1, 1'b0, 5'd11, 64'h55, cyc + 4);
    tick();
    present(2'b00, 64'h55, 2'd0, 1'b0, 64'd0, 5'd11);
    dmem_ready = 1'b1;
    check("held_blocked", {63'd0, mem_blocked}, 64'd1);
    tick();
    dmem_ready = 1'b0;
    dmem_resp = 1'b1;
    dmem_rdata = 64'h0000_0000_ABCD_0000;
    tick();
    dmem_resp = 1'b0;
    tick();
    exe_mem = 1'b0;
    tick();

    // Reset in WAIT; the late response must not complete anything.
    present(2'b01, 64'h8000, 2'd3, 1'b0, 64'd0, 5'd20);
    tick();
    exe_mem = 1'b0;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_wait_blocked", {63'd0, mem_blocked}, 64'd0);
    check("rst_wait_req", {63'd0, dmem_req}, 64'd0);
    tick();
    reset = 1'b0;
    dmem_resp = 1'b1;
    dmem_rdata = 64'h1234;
    tick();
    dmem_resp = 1'b0;

    // Reset in REQ while memory stalls.
    present(2'b10, 64'h9000, 2'd3, 1'b0, 64'h99, 5'd21);
    tick();
    exe_mem = 1'b0;
    check("req_before_rst", {63'd0, dmem_req}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_req_req", {63'd0, dmem_req}, 64'd0);
    check("rst_req_blocked", {63'd0, mem_blocked}, 64'd0);
    tick();
    reset = 1'b0;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    tick();
    tick();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
